hc05_at_responder: RTL and testbench
====================================

# hc05_at_responder

Behavioural-synthesisable stand-in for the HC-05 Bluetooth module, used on the far end of the FPGA's UART link for loopback benches and on-board self-test. It receives bytes on `rxd`, assembles AT command lines terminated by CR LF, and answers on `txd` with "OK\r\n" or "ERROR\r\n". In data mode it counts payload bytes and drives `bt_state` to emulate a paired link. Contains its own bit-level UART receiver and transmitter, plus the response sequencer.

## Interface
- `CLOCK_SPEED`, 1000000: clock frequency in Hz.
- `BAUD_RATE`, 38400: line rate; `CPD = CLOCK_SPEED / BAUD_RATE`, integer-truncated (26 at defaults), 10-bit.
- `LINE_MAX`, 16: maximum stored command bytes, excluding CR LF.
- `LINK_DELAY`, 1000: cycles from entering data mode until `bt_state` rises.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rxd`  in  1  serial input, idle high; connects to the FPGA's `fpga_txd`.
- `txd`  out  1  serial output, idle high; connects to the FPGA's `fpga_rxd`.
- `at_mode`  in  1  1 = AT command mode (KEY pin high); 0 = data mode.
- `bt_state`  out  1  emulated STATE pin; high = paired.
- `rx_byte`  out  8  last byte received with a valid stop bit.
- `rx_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `busy`  out  1  response or echo transmission in progress.
- `cmd_count`  out  8  lines answered OK; wraps 255->0.
- `err_count`  out  8  framing errors plus ERROR responses; saturates at 255.
- `data_count`  out  16  bytes received in data mode; wraps.

## Operation
- Receiver: `rxd` passes through a 2-flop synchroniser. A falling edge starts a frame. At `CPD/2` cycles the start bit is re-sampled; if high, the event is a glitch and is discarded with no count. Otherwise 8 data bits are sampled LSB first every `CPD` cycles, then the stop bit. A high stop bit loads `rx_byte` and pulses `rx_valid`. A low stop bit discards the byte, increments `err_count`, and the receiver waits for `rxd` high before re-arming.
- Line assembler (AT mode): valid bytes other than 0x0D/0x0A are stored at index `len` while `len < LINE_MAX`. Beyond that, bytes are dropped and `ovf` is set.
- Line completion is 0x0A immediately preceded by 0x0D.
  - `len == 0`, no overflow: line ignored, no response.
  - `ovf`: respond "ERROR\r\n".
  - `len >= 2`, `buf[0] == 0x41`, and `buf[1] == 0x54`: respond "OK\r\n" and increment `cmd_count`.
  - Any other line: respond "ERROR\r\n".
  - In every case, `len` and `ovf` are cleared.
- A lone 0x0D or 0x0A is stored as a normal byte only when it is not part of the CR LF pair. A 0x0D followed by any byte other than 0x0A stores both bytes.
- Response FSM: `R_IDLE -> R_LOAD -> R_SEND -> (next char ? R_LOAD : R_IDLE)`. `R_LOAD` fetches the character from an internal ROM. `R_SEND` runs the transmitter: start bit, 8 data bits LSB first, stop bit, each `CPD` cycles. `busy` is high in every state except `R_IDLE`.
- A line that completes while `busy` is set is not answered. It increments `err_count`.
- Data mode (`at_mode == 0`):
  - Each valid byte increments `data_count`.
  - The line buffer is held cleared.
  - A counter runs while `at_mode` stays low; `bt_state` goes high when it reaches `LINK_DELAY`.
  - `at_mode` going high clears `bt_state` and the counter on the next edge.
- The receiver never stalls; reception continues during transmission.

## Timing
- Reset values: `txd = 1`, `bt_state = 0`, `rx_byte = 0`, `rx_valid = 0`, `busy = 0`, all counters 0, FSM in `R_IDLE`.
- Reset is asynchronous: `txd` returns high immediately even mid-frame.
- One frame lasts `10*CPD` cycles (260 at defaults).
- Latency: with the `\n` stop bit sampled on edge S, `rx_valid` pulses in cycle S+1 and `busy` rises with `txd` falling at edge S+2.
- Response characters are back-to-back with no idle gap; "OK\r\n" occupies exactly `40*CPD` cycles.
- `rxd` to internal sample: 2-cycle synchroniser delay.

## Configuration
- `HC05_ECHO_EN`:
  - Defined: in data mode, every valid received byte is retransmitted on `txd` starting 2 cycles after its `rx_valid`, using the same transmitter and `busy`. A byte arriving while `busy` is set is not echoed and increments `err_count`.
  - Undefined: `txd` is driven only by AT responses, and stays high in data mode.

## Test plan
- AT mode, send "AT\r\n" at 38400 baud -> `txd` emits 0x4F 0x4B 0x0D 0x0A starting 2 cycles after the last stop sample; `cmd_count = 1`, `busy` high for 1040 cycles.
- Send "XY\r\n" -> "ERROR\r\n" on `txd`, `err_count = 1`, `cmd_count` unchanged.
- Send "AT" plus 18 'A' bytes plus "\r\n" (20 payload bytes) -> single "ERROR\r\n", buffer cleared; a following "AT\r\n" returns "OK\r\n".
- 0x55 frame with stop bit forced low -> no `rx_valid`, `err_count = 1`. A separate 5-cycle low glitch on `rxd` -> no counts change.
- Drop `at_mode` -> `bt_state` rises after exactly 1000 cycles. Send 3 bytes -> `data_count = 3`. Raise `at_mode` -> `bt_state` low next edge.
- Assert `reset` mid-way through "OK" -> `txd = 1` immediately, `busy = 0`, counters 0. With `HC05_ECHO_EN` defined, data-mode byte 0xA5 is echoed as 0xA5.

Source files
------------

// File: rtl/hc05_at_responder_if.sv
// hc05_at_responder_if: serial line, mode pin and status signals between
// the FPGA-side bench/master and the HC-05 responder model.
interface hc05_at_responder_if;
    logic        rxd;
    logic        txd;
    logic        at_mode;
    logic        bt_state;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic [7:0]  cmd_count;
    logic [7:0]  err_count;
    logic [15:0] data_count;

    modport master (
        output rxd, at_mode,
        input  txd, bt_state, rx_byte, rx_valid, busy, cmd_count, err_count, data_count
    );

    modport slave (
        input  rxd, at_mode,
        output txd, bt_state, rx_byte, rx_valid, busy, cmd_count, err_count, data_count
    );
endinterface

// File: rtl/hc05_at_responder.sv
// hc05_at_responder: HC-05 stand-in. UART receiver, AT line assembler,
// OK/ERROR response sequencer with its own UART transmitter, data-mode
// byte counter and emulated STATE pin.
// Optional feature: define HC05_ECHO_EN to echo data-mode bytes on txd.
module hc05_at_responder #(
    parameter int CLOCK_SPEED = 1000000,
    parameter int BAUD_RATE   = 38400,
    parameter int LINE_MAX    = 16,
    parameter int LINK_DELAY  = 1000
) (
    input logic                clock,
    input logic                reset,
    hc05_at_responder_if.slave bus
);
    localparam logic [9:0] CPD  = 10'(CLOCK_SPEED / BAUD_RATE);
    localparam logic [9:0] HALF = CPD >> 1;
    localparam int LEN_W  = $clog2(LINE_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_MAX);
    localparam int LINK_W = $clog2(LINK_DELAY + 1);
    localparam logic [LINK_W-1:0] LINK_TOP = LINK_W'(LINK_DELAY);
    localparam logic [3:0] OK_FIRST = 4'd0, OK_LAST = 4'd3, ERR_FIRST = 4'd4, ERR_LAST = 4'd10;
`ifdef HC05_ECHO_EN
    localparam logic ECHO_EN = 1'b1;
`else
    localparam logic ECHO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rspState_t;

    logic rxdMeta_q, rxdSync_q;
    rxState_t rxState_q, rxState_d;
    logic [9:0] rxCnt_q, rxCnt_d;
    logic [2:0] rxBit_q, rxBit_d;
    logic [7:0] rxShift_q, rxShift_d, rxByte_q, rxByte_d;
    logic rxValid_q, rxValid_d, frameErr;

    logic [LEN_W-1:0] lineLen_q, lineLen_d;
    logic lineOvf_q, lineOvf_d, crPend_q, crPend_d;
    logic [7:0] buf0_q, buf0_d, buf1_q, buf1_d, echoByte_q, echoByte_d, storeVal;
    logic respReq_q, respReq_d, respEcho_q, respEcho_d;
    logic [3:0] respFirst_q, respFirst_d, respLast_q, respLast_d;
    logic storeCr, storeByte, doStore, lineDone, lineErr, cmdInc, dataInc, busyNow;

    rspState_t rspState_q, rspState_d;
    logic [3:0] charIdx_q, charIdx_d, lastIdx_q, lastIdx_d, bitIdx_q, bitIdx_d;
    logic useEcho_q, useEcho_d, txd_q, txd_d;
    logic [7:0] txData_q, txData_d;
    logic [9:0] bitCnt_q, bitCnt_d;

    logic [LINK_W-1:0] linkCnt_q;
    logic btState_q;
    logic [7:0] cmdCount_q, errCount_q;
    logic [15:0] dataCount_q;
    logic [1:0] errInc;
    logic [8:0] errSum;

    function automatic logic [7:0] romChar(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h4F;
            4'd1:    return 8'h4B;
            4'd2:    return 8'h0D;
            4'd3:    return 8'h0A;
            4'd4:    return 8'h45;
            4'd5:    return 8'h52;
            4'd6:    return 8'h52;
            4'd7:    return 8'h4F;
            4'd8:    return 8'h52;
            4'd9:    return 8'h0D;
            4'd10:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    assign busyNow = (rspState_q != R_IDLE) || respReq_q;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= bus.rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            rxByte_q  <= '0;
            rxValid_q <= 1'b0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
            rxByte_q  <= rxByte_d;
            rxValid_q <= rxValid_d;
        end
    end

    // Receiver: start-bit recheck at half a bit, then LSB-first data and stop; a low stop waits for idle.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q + 10'd1;
        rxBit_d   = rxBit_q;
        rxShift_d = rxShift_q;
        rxByte_d  = rxByte_q;
        rxValid_d = 1'b0;
        frameErr  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                if (!rxdSync_q) rxState_d = RX_START;
            end
            RX_START: if (rxCnt_q == HALF - 10'd1) begin
                rxCnt_d   = '0;
                rxBit_d   = '0;
                rxState_d = rxdSync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rxCnt_q == CPD - 10'd1) begin
                rxCnt_d   = '0;
                rxShift_d = {rxdSync_q, rxShift_q[7:1]};
                rxBit_d   = rxBit_q + 3'd1;
                if (rxBit_q == 3'd7) rxState_d = RX_STOP;
            end
            RX_STOP: if (rxCnt_q == CPD - 10'd1) begin
                rxCnt_d = '0;
                if (rxdSync_q) begin
                    rxByte_d  = rxShift_q;
                    rxValid_d = 1'b1;
                    rxState_d = RX_IDLE;
                end else begin
                    frameErr  = 1'b1;
                    rxState_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                rxCnt_d = '0;
                if (rxdSync_q) rxState_d = RX_IDLE;
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Line assembler and response request; only the first two stored bytes decide OK vs ERROR.
    always_comb begin
        lineLen_d   = lineLen_q;
        lineOvf_d   = lineOvf_q;
        crPend_d    = crPend_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        echoByte_d  = echoByte_q;
        respReq_d   = 1'b0;
        respFirst_d = respFirst_q;
        respLast_d  = respLast_q;
        respEcho_d  = respEcho_q;
        storeCr     = 1'b0;
        storeByte   = 1'b0;
        doStore     = 1'b0;
        storeVal    = 8'h00;
        lineDone    = 1'b0;
        lineErr     = 1'b0;
        cmdInc      = 1'b0;
        dataInc     = 1'b0;
        if (!bus.at_mode) begin
            lineLen_d = '0;
            lineOvf_d = 1'b0;
            crPend_d  = 1'b0;
            if (rxValid_q) begin
                dataInc = 1'b1;
                if (ECHO_EN) begin
                    if (busyNow) begin
                        lineErr = 1'b1;
                    end else begin
                        respReq_d   = 1'b1;
                        respFirst_d = 4'd0;
                        respLast_d  = 4'd0;
                        respEcho_d  = 1'b1;
                        echoByte_d  = rxByte_q;
                    end
                end
            end
        end else if (rxValid_q) begin
            if (rxByte_q == 8'h0D) begin
                storeCr  = crPend_q;
                crPend_d = 1'b1;
            end else if (rxByte_q == 8'h0A && crPend_q) begin
                lineDone = 1'b1;
                crPend_d = 1'b0;
            end else begin
                storeCr   = crPend_q;
                storeByte = 1'b1;
                crPend_d  = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            doStore  = (k == 0) ? storeCr : storeByte;
            storeVal = (k == 0) ? 8'h0D : rxByte_q;
            if (doStore) begin
                if (lineLen_d < LEN_MAX) begin
                    if (lineLen_d == LEN_W'(0)) buf0_d = storeVal;
                    else if (lineLen_d == LEN_W'(1)) buf1_d = storeVal;
                    lineLen_d = lineLen_d + LEN_W'(1);
                end else begin
                    lineOvf_d = 1'b1;
                end
            end
        end
        if (lineDone) begin
            lineLen_d = '0;
            lineOvf_d = 1'b0;
            if (lineLen_q != LEN_W'(0) || lineOvf_q) begin
                respEcho_d = 1'b0;
                if (busyNow) begin
                    lineErr = 1'b1;
                end else if (!lineOvf_q && lineLen_q >= LEN_W'(2) && buf0_q == 8'h41 && buf1_q == 8'h54) begin
                    respReq_d   = 1'b1;
                    respFirst_d = OK_FIRST;
                    respLast_d  = OK_LAST;
                    cmdInc      = 1'b1;
                end else begin
                    respReq_d   = 1'b1;
                    respFirst_d = ERR_FIRST;
                    respLast_d  = ERR_LAST;
                    lineErr     = 1'b1;
                end
            end
        end
    end

    // Line assembler and request registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lineLen_q   <= '0;
            lineOvf_q   <= 1'b0;
            crPend_q    <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            echoByte_q  <= '0;
            respReq_q   <= 1'b0;
            respFirst_q <= '0;
            respLast_q  <= '0;
            respEcho_q  <= 1'b0;
        end else begin
            lineLen_q   <= lineLen_d;
            lineOvf_q   <= lineOvf_d;
            crPend_q    <= crPend_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            echoByte_q  <= echoByte_d;
            respReq_q   <= respReq_d;
            respFirst_q <= respFirst_d;
            respLast_q  <= respLast_d;
            respEcho_q  <= respEcho_d;
        end
    end

    // Response sequencer: R_LOAD is the first cycle of each start bit, so characters run back to back.
    always_comb begin
        rspState_d = rspState_q;
        charIdx_d  = charIdx_q;
        lastIdx_d  = lastIdx_q;
        useEcho_d  = useEcho_q;
        txData_d   = txData_q;
        bitIdx_d   = bitIdx_q;
        bitCnt_d   = bitCnt_q;
        txd_d      = txd_q;
        case (rspState_q)
            R_IDLE: begin
                txd_d = 1'b1;
                if (respReq_q) begin
                    rspState_d = R_LOAD;
                    charIdx_d  = respFirst_q;
                    lastIdx_d  = respLast_q;
                    useEcho_d  = respEcho_q;
                    txd_d      = 1'b0;
                end
            end
            R_LOAD: begin
                txData_d   = useEcho_q ? echoByte_q : romChar(charIdx_q);
                bitIdx_d   = 4'd0;
                bitCnt_d   = 10'd1;
                txd_d      = 1'b0;
                rspState_d = R_SEND;
            end
            R_SEND: begin
                if (bitCnt_q == CPD - 10'd1) begin
                    bitCnt_d = '0;
                    if (bitIdx_q == 4'd9) begin
                        if (charIdx_q != lastIdx_q) begin
                            charIdx_d  = charIdx_q + 4'd1;
                            rspState_d = R_LOAD;
                            txd_d      = 1'b0;
                        end else begin
                            rspState_d = R_IDLE;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                        txd_d    = (bitIdx_q < 4'd8) ? txData_q[bitIdx_q[2:0]] : 1'b1;
                    end
                end else begin
                    bitCnt_d = bitCnt_q + 10'd1;
                end
            end
            default: rspState_d = R_IDLE;
        endcase
    end

    // Response sequencer state register; reset forces txd idle high at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rspState_q <= R_IDLE;
            charIdx_q  <= '0;
            lastIdx_q  <= '0;
            useEcho_q  <= 1'b0;
            txData_q   <= '0;
            bitIdx_q   <= '0;
            bitCnt_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            rspState_q <= rspState_d;
            charIdx_q  <= charIdx_d;
            lastIdx_q  <= lastIdx_d;
            useEcho_q  <= useEcho_d;
            txData_q   <= txData_d;
            bitIdx_q   <= bitIdx_d;
            bitCnt_q   <= bitCnt_d;
            txd_q      <= txd_d;
        end
    end

    assign errInc = {1'b0, frameErr} + {1'b0, lineErr};
    assign errSum = {1'b0, errCount_q} + {7'b0, errInc};

    // Counters and emulated pairing delay while in data mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmdCount_q  <= '0;
            errCount_q  <= '0;
            dataCount_q <= '0;
            linkCnt_q   <= '0;
            btState_q   <= 1'b0;
        end else begin
            if (cmdInc) cmdCount_q <= cmdCount_q + 8'd1;
            if (dataInc) dataCount_q <= dataCount_q + 16'd1;
            errCount_q <= errSum[8] ? 8'hFF : errSum[7:0];
            if (bus.at_mode) begin
                linkCnt_q <= '0;
                btState_q <= 1'b0;
            end else if (linkCnt_q != LINK_TOP) begin
                linkCnt_q <= linkCnt_q + LINK_W'(1);
                btState_q <= (linkCnt_q == LINK_TOP - LINK_W'(1));
            end
        end
    end

    assign bus.txd        = txd_q;
    assign bus.bt_state   = btState_q;
    assign bus.rx_byte    = rxByte_q;
    assign bus.rx_valid   = rxValid_q;
    assign bus.busy       = rspState_q != R_IDLE;
    assign bus.cmd_count  = cmdCount_q;
    assign bus.err_count  = errCount_q;
    assign bus.data_count = dataCount_q;
endmodule

// File: tb/tb_hc05_at_responder.sv
// tb_hc05_at_responder: drives AT lines and data-mode bytes over rxd and
// decodes txd frames against a queue of expected response bytes.
module tb_hc05_at_responder;
    localparam int CPD = 1000000 / 38400;
    localparam int LINK_DELAY = 1000;

    logic clock = 1'b0;
    logic reset;
    hc05_at_responder_if bus();

    hc05_at_responder dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int rxValidCount = 0;
    logic [7:0] expQ[$];

    // Count rx_valid pulses, sampled mid-cycle.
    always @(negedge clock) if (bus.rx_valid === 1'b1) rxValidCount++;

    // Decode txd frames and compare each byte with the head of the expected queue.
    initial begin : txMonitor
        logic [7:0] b;
        logic [7:0] e;
        logic stopBit;
        bit sawReset;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && bus.txd === 1'b0) begin
                sawReset = 1'b0;
                b = '0;
                repeat (CPD / 2) begin @(negedge clock); if (reset !== 1'b0) sawReset = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPD) begin @(negedge clock); if (reset !== 1'b0) sawReset = 1'b1; end
                    b[i] = bus.txd;
                end
                repeat (CPD) begin @(negedge clock); if (reset !== 1'b0) sawReset = 1'b1; end
                stopBit = bus.txd;
                if (!sawReset) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL txByte: got 0x%02h with nothing expected", b);
                    end else begin
                        e = expQ.pop_front();
                        if (b !== e || stopBit !== 1'b1) begin
                            failures++;
                            $display("[TB] FAIL txByte: got 0x%02h stop=%b, expected 0x%02h stop=1", b, stopBit, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        bus.rxd = 1'b0;
        tick(CPD);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            tick(CPD);
        end
        bus.rxd = stopBit;
        tick(CPD);
        bus.rxd = 1'b1;
    endtask

    task automatic sendText(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b1);
    endtask

    task automatic sendCrLf();
        sendByte(8'h0D, 1'b1);
        sendByte(8'h0A, 1'b1);
    endtask

    task automatic pushOk();
        expQ.push_back(8'h4F); expQ.push_back(8'h4B);
        expQ.push_back(8'h0D); expQ.push_back(8'h0A);
    endtask

    task automatic pushError();
        expQ.push_back(8'h45); expQ.push_back(8'h52); expQ.push_back(8'h52);
        expQ.push_back(8'h4F); expQ.push_back(8'h52);
        expQ.push_back(8'h0D); expQ.push_back(8'h0A);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((bus.busy !== 1'b0 || expQ.size() != 0) && n < 4000) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            failures++;
            $display("[TB] FAIL %s idle: busy=%b pending=%0d, required idle within 4000 cycles", name, bus.busy, expQ.size());
        end
    endtask

    task automatic checkCounts(input string name, input int cmd, input int err);
        checks++;
        if (bus.cmd_count !== 8'(cmd)) begin
            failures++;
            $display("[TB] FAIL %s cmd_count: got %0d, expected %0d", name, bus.cmd_count, cmd);
        end
        checks++;
        if (bus.err_count !== 8'(err)) begin
            failures++;
            $display("[TB] FAIL %s err_count: got %0d, expected %0d", name, bus.err_count, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rxd = 1'b1;
        bus.at_mode = 1'b1;
        tick(3);
        checks++; if (bus.txd !== 1'b1) begin failures++; $display("[TB] FAIL reset txd: got %b, expected 1", bus.txd); end
        checks++; if (bus.bt_state !== 1'b0) begin failures++; $display("[TB] FAIL reset bt_state: got %b, expected 0", bus.bt_state); end
        checks++; if (bus.rx_byte !== 8'h00) begin failures++; $display("[TB] FAIL reset rx_byte: got 0x%02h, expected 0x00", bus.rx_byte); end
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset rx_valid: got %b, expected 0", bus.rx_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b, expected 0", bus.busy); end
        checks++; if (bus.data_count !== 16'h0) begin failures++; $display("[TB] FAIL reset data_count: got %0d, expected 0", bus.data_count); end
        checkCounts("reset", 0, 0);
        reset = 1'b0;
        tick(5);
    endtask

    task automatic test_at_ok();
        int n;
        int lat;
        int width;
        pushOk();
        sendText("AT");
        sendByte(8'h0D, 1'b1);
        fork
            sendByte(8'h0A, 1'b1);
            begin
                n = 0;
                while (bus.rx_valid !== 1'b1 && n < 400) begin tick(1); n++; end
                lat = 0;
                while (bus.busy !== 1'b1 && lat < 20) begin tick(1); lat++; end
                checks++;
                if (lat != 2) begin failures++; $display("[TB] FAIL okLatency: busy after %0d cycles from rx_valid, expected 2", lat); end
                checks++;
                if (bus.txd !== 1'b0) begin failures++; $display("[TB] FAIL okStartBit: txd=%b, expected 0", bus.txd); end
                width = 0;
                while (bus.busy === 1'b1 && width < 3000) begin tick(1); width++; end
                checks++;
                if (width != 40 * CPD) begin failures++; $display("[TB] FAIL okBusyWidth: got %0d cycles, expected %0d", width, 40 * CPD); end
            end
        join
        waitIdle("ok");
        checkCounts("ok", 1, 0);
    endtask

    task automatic test_error();
        pushError();
        sendText("XY");
        sendCrLf();
        waitIdle("error");
        checkCounts("error", 1, 1);
    endtask

    task automatic test_overflow();
        pushError();
        sendText("AT");
        repeat (18) sendByte(8'h41, 1'b1);
        sendCrLf();
        waitIdle("overflow");
        checkCounts("overflow", 1, 2);
        pushOk();
        sendText("AT");
        sendCrLf();
        waitIdle("afterOverflow");
        checkCounts("afterOverflow", 2, 2);
    endtask

    task automatic test_cr_handling();
        pushError();
        sendByte(8'h41, 1'b1);
        sendByte(8'h0D, 1'b1);
        sendByte(8'h54, 1'b1);
        sendCrLf();
        waitIdle("loneCr");
        checkCounts("loneCr", 2, 3);
        sendCrLf();
        tick(20);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL emptyLine busy: got %b, expected 0", bus.busy); end
        checkCounts("emptyLine", 2, 3);
    endtask

    task automatic test_back_to_back();
        pushOk();
        sendText("AT");
        sendCrLf();
        sendText("X");
        sendCrLf();
        waitIdle("busyCollision");
        checkCounts("busyCollision", 3, 4);
    endtask

    task automatic test_framing();
        int base;
        base = rxValidCount;
        sendByte(8'h55, 1'b0);
        tick(CPD);
        checks++;
        if (rxValidCount != base) begin failures++; $display("[TB] FAIL framing rx_valid: got %0d pulses, expected 0", rxValidCount - base); end
        checks++;
        if (bus.rx_byte !== 8'h0A) begin failures++; $display("[TB] FAIL framing rx_byte: got 0x%02h, expected 0x0A", bus.rx_byte); end
        checkCounts("framing", 3, 5);
        bus.rxd = 1'b0;
        tick(5);
        bus.rxd = 1'b1;
        tick(3 * CPD);
        checks++;
        if (rxValidCount != base) begin failures++; $display("[TB] FAIL glitch rx_valid: got %0d pulses, expected 0", rxValidCount - base); end
        checkCounts("glitch", 3, 5);
    endtask

    task automatic test_reset_mid();
        int n;
        pushOk();
        sendText("AT");
        sendByte(8'h0D, 1'b1);
        fork
            sendByte(8'h0A, 1'b1);
            begin
                n = 0;
                while (bus.busy !== 1'b1 && n < 400) begin tick(1); n++; end
                tick(5 * CPD + 5);
                checks++;
                if (bus.txd !== 1'b0) begin failures++; $display("[TB] FAIL midBit4: txd=%b, expected 0", bus.txd); end
                reset = 1'b1;
                #1;
                checks++;
                if (bus.txd !== 1'b1) begin failures++; $display("[TB] FAIL resetMid txd: got %b, expected 1", bus.txd); end
                checks++;
                if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL resetMid busy: got %b, expected 0", bus.busy); end
                checkCounts("resetMid", 0, 0);
            end
        join
        expQ.delete();
        tick(3);
        reset = 1'b0;
        tick(12 * CPD);
    endtask

    task automatic test_data_mode();
        int n;
        logic [7:0] bytes[3];
        bytes[0] = 8'hA5; bytes[1] = 8'h0D; bytes[2] = 8'h0A;
        bus.at_mode = 1'b0;
        n = 0;
        while (bus.bt_state !== 1'b1 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n != LINK_DELAY) begin failures++; $display("[TB] FAIL linkDelay: bt_state rose after %0d cycles, expected %0d", n, LINK_DELAY); end
        tick(1);
        for (int i = 0; i < 3; i++) begin
`ifdef HC05_ECHO_EN
            expQ.push_back(bytes[i]);
`endif
            sendByte(bytes[i], 1'b1);
            tick(30);
        end
        waitIdle("dataMode");
        checks++;
        if (bus.data_count !== 16'd3) begin failures++; $display("[TB] FAIL data_count: got %0d, expected 3", bus.data_count); end
        checkCounts("dataMode", 0, 0);
        checks++;
        if (bus.bt_state !== 1'b1) begin failures++; $display("[TB] FAIL bt_state held: got %b, expected 1", bus.bt_state); end
        bus.at_mode = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (bus.bt_state !== 1'b0) begin failures++; $display("[TB] FAIL bt_state clear: got %b, expected 0", bus.bt_state); end
        tick(2);
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] start, CPD=%0d", CPD);
        test_reset();
        test_at_ok();
        test_error();
        test_overflow();
        test_cr_handling();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        test_data_mode();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL leftover: %0d expected bytes never seen, expected 0", expQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
